int_pc_ctrl: RTL and testbench

Program-counter and interrupt sequencer for the single-cycle CPU, directly upstream of the main controller. It holds PC, computes next-PC from the controller's `Branch`/`eret` decisions, and detects the external interrupt. It takes the interrupt at an instruction boundary, saves EPC and vectors to the handler. It drives `int_code` so the controller honours `eret` only while a handler is active.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/int_sync.sv | 27 ++
 rtl/int_pc_ctrl.sv | 98 +++++++++
 tb/tb_int_pc_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller Branch encodings, PC/interrupt sequencer states
// and the default interrupt handler entry address.
package cpu_pkg;

    localparam logic [1:0] BR_SEQ = 2'b00;
    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_J   = 2'b10;
    localparam logic [1:0] BR_JR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ISR  = 2'b01,
        S_RET  = 2'b10
    } state_t;

    localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0004;

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchroniser for an asynchronous level request followed by a
// rising-edge detector; a held-high level yields a single one-cycle rise.
module int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], async_in};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/int_pc_ctrl.sv
// Program counter and single-level interrupt sequencer for the single-cycle CPU:
// next-PC selection, interrupt take at instruction boundaries, EPC save and eret return.
module int_pc_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR  = DEF_INT_VECTOR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MIO_ready,
    input  logic [1:0]  Branch,
    input  logic        eret,
    input  logic [25:0] inst_field,
    input  logic [31:0] rs_data,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4,
    output logic [31:0] EPC,
    output logic        int_code,
    output logic        int_taken
);

    state_t      state;
    logic        pending;
    logic        rise;
    logic        take;
    logic [31:0] seq_pc;

    int_sync #(.STAGES(SYNC_STAGES)) u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INT),
        .rise     (rise)
    );

    assign PC_plus4 = PC_out + 32'd4;

    always_comb begin
        seq_pc = PC_plus4;
        case (Branch)
            BR_SEQ: seq_pc = PC_plus4;
            BR_BEQ: seq_pc = PC_plus4 + {{14{inst_field[15]}}, inst_field[15:0], 2'b00};
            BR_J:   seq_pc = {PC_plus4[31:28], inst_field, 2'b00};
            BR_JR:  seq_pc = rs_data;
            default: seq_pc = PC_plus4;
        endcase
    end

    assign take = MIO_ready && (state == S_IDLE) && pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            PC_out    <= RESET_PC;
            EPC       <= 32'h0;
            pending   <= 1'b0;
            int_code  <= 1'b0;
            int_taken <= 1'b0;
        end else begin
            int_taken <= 1'b0;
            // A rise on the take edge survives the clear, so it is not lost.
            pending   <= (pending & ~take) | rise;
            if (MIO_ready) begin
                case (state)
                    S_IDLE: begin
                        if (pending) begin
                            state     <= S_ISR;
                            EPC       <= seq_pc;
                            PC_out    <= INT_VECTOR;
                            int_code  <= 1'b1;
                            int_taken <= 1'b1;
                        end else begin
                            PC_out <= seq_pc;
                        end
                    end
                    S_ISR: begin
                        if (eret) begin
                            state    <= S_RET;
                            PC_out   <= EPC;
                            int_code <= 1'b0;
                        end else begin
                            PC_out <= seq_pc;
                        end
                    end
                    // One guaranteed instruction after eret before another take.
                    S_RET: begin
                        state  <= S_IDLE;
                        PC_out <= seq_pc;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_pc_ctrl.sv
// Bench for int_pc_ctrl: next-PC vector table, randomized no-interrupt run against
// an arithmetic reference, and hand sequences for interrupt take/return corners.
module tb_int_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        MIO_ready;
    logic [1:0]  Branch;
    logic        eret;
    logic [25:0] inst_field;
    logic [31:0] rs_data;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;
    logic [31:0] EPC;
    logic        int_code;
    logic        int_taken;

    int checks = 0;
    int errors = 0;

    int_pc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .INT        (INT),
        .MIO_ready  (MIO_ready),
        .Branch     (Branch),
        .eret       (eret),
        .inst_field (inst_field),
        .rs_data    (rs_data),
        .PC_out     (PC_out),
        .PC_plus4   (PC_plus4),
        .EPC        (EPC),
        .int_code   (int_code),
        .int_taken  (int_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_pc;
        logic [1:0]  br;
        logic [25:0] field;
        logic [31:0] rs;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        INT        = 1'b0;
        MIO_ready  = 1'b1;
        Branch     = 2'b00;
        eret       = 1'b0;
        inst_field = '0;
        rs_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        Branch  = 2'b11;
        rs_data = v;
        step();
        Branch  = 2'b00;
    endtask

    // Reference next PC straight from the instruction semantics.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] br,
                                             input logic [25:0] f, input logic [31:0] rs);
        shortint     off;
        logic [31:0] nxt;
        off = shortint'(f[15:0]);
        case (br)
            2'd0: nxt = pc + 32'd4;
            2'd1: nxt = pc + 32'd4 + 32'(int'(off) * 4);
            2'd2: nxt = ((pc + 32'd4) & 32'hF000_0000) | (32'(f) * 32'd4);
            default: nxt = rs;
        endcase
        return nxt;
    endfunction

    initial begin
        logic [31:0] mpc;

        vecs[0] = '{32'h0000_0100, 2'b01, 26'h000_FFFE, 32'h0,         32'h0000_00FC};
        vecs[1] = '{32'h0000_00FC, 2'b10, 26'h000_0040, 32'h0,         32'h0000_0100};
        vecs[2] = '{32'h0000_0100, 2'b11, 26'h0,        32'h0000_2000, 32'h0000_2000};
        vecs[3] = '{32'hFFFF_FFFC, 2'b00, 26'h0,        32'h0,         32'h0000_0000};
        vecs[4] = '{32'h1000_0000, 2'b01, 26'h000_7FFF, 32'h0,         32'h1002_0000};
        vecs[5] = '{32'hF000_0010, 2'b10, 26'h3FF_FFFF, 32'h0,         32'hFFFF_FFFC};
        vecs[6] = '{32'h0000_0000, 2'b01, 26'h000_8000, 32'h0,         32'hFFFE_0004};
        vecs[7] = '{32'hFFFF_FFFC, 2'b10, 26'h000_0001, 32'h0,         32'h0000_0004};

        // Reset state and sequential fetch
        do_reset();
        chk("reset_pc", PC_out, 32'h0);
        chk("reset_epc", EPC, 32'h0);
        chk("reset_int_code", 32'(int_code), 32'h0);
        chk("reset_int_taken", 32'(int_taken), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("seq_pc", PC_out, 32'(i * 4));
        end

        // Next-PC vector table
        for (int i = 0; i < 8; i++) begin
            set_pc(vecs[i].start_pc);
            chk("vec_start", PC_out, vecs[i].start_pc);
            chk("vec_plus4", PC_plus4, vecs[i].start_pc + 32'd4);
            Branch     = vecs[i].br;
            inst_field = vecs[i].field;
            rs_data    = vecs[i].rs;
            step();
            chk("vec_next", PC_out, vecs[i].exp_pc);
        end
        Branch = 2'b00;

        // Randomized no-interrupt run, stalls and stray eret included
        do_reset();
        mpc = 32'h0;
        for (int i = 0; i < 300; i++) begin
            Branch     = 2'($urandom_range(0, 3));
            inst_field = 26'($urandom);
            rs_data    = $urandom;
            MIO_ready  = ($urandom_range(0, 3) != 0);
            eret       = ($urandom_range(0, 7) == 0);
            if (MIO_ready) mpc = ref_next(mpc, Branch, inst_field, rs_data);
            step();
            chk("rand_pc", PC_out, mpc);
            chk("rand_plus4", PC_plus4, mpc + 32'd4);
            chk("rand_int_code", 32'(int_code), 32'h0);
        end
        MIO_ready = 1'b1;
        eret      = 1'b0;
        Branch    = 2'b00;

        // Interrupt take latency, handler run and eret return
        do_reset();
        set_pc(32'h40);
        INT = 1'b1;
        step(); chk("irq_t0_pc", PC_out, 32'h44);
        step(); chk("irq_t1_pc", PC_out, 32'h48);
        step(); chk("irq_t2_pc", PC_out, 32'h4C);
        chk("irq_t2_taken", 32'(int_taken), 32'h0);
        step();
        chk("irq_taken", 32'(int_taken), 32'h1);
        chk("irq_vec_pc", PC_out, 32'h4);
        chk("irq_epc", EPC, 32'h50);
        chk("irq_int_code", 32'(int_code), 32'h1);
        INT = 1'b0;
        step();
        chk("irq_pulse_end", 32'(int_taken), 32'h0);
        chk("isr_pc", PC_out, 32'h8);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_pc", PC_out, 32'h50);
        chk("eret_int_code", 32'(int_code), 32'h0);
        step();
        chk("post_ret_pc", PC_out, 32'h54);

        // Take coinciding with a taken branch, then a second rise in the handler
        do_reset();
        set_pc(32'h40);
        INT = 1'b1;
        step(); step(); step();
        chk("coin_pre_pc", PC_out, 32'h4C);
        Branch     = 2'b01;
        inst_field = 26'h00C;
        step();
        Branch = 2'b00;
        INT    = 1'b0;
        chk("coin_taken", 32'(int_taken), 32'h1);
        chk("coin_epc", EPC, 32'h80);
        chk("coin_pc", PC_out, 32'h4);
        step();
        INT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nest_taken", 32'(int_taken), 32'h0);
            chk("nest_int_code", 32'(int_code), 32'h1);
            chk("nest_pc", PC_out, 32'hC + 32'(i * 4));
        end
        INT  = 1'b0;
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("nest_eret_pc", PC_out, 32'h80);
        chk("nest_eret_taken", 32'(int_taken), 32'h0);
        step();
        chk("ret_one_inst_pc", PC_out, 32'h84);
        chk("ret_one_inst_taken", 32'(int_taken), 32'h0);
        step();
        chk("second_taken", 32'(int_taken), 32'h1);
        chk("second_pc", PC_out, 32'h4);
        chk("second_epc", EPC, 32'h88);

        // Stall with pending interrupt, then async reset inside the handler
        do_reset();
        set_pc(32'h200);
        MIO_ready = 1'b0;
        INT       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc", PC_out, 32'h200);
            chk("stall_taken", 32'(int_taken), 32'h0);
        end
        MIO_ready = 1'b1;
        step();
        chk("stall_release_taken", 32'(int_taken), 32'h1);
        chk("stall_release_pc", PC_out, 32'h4);
        chk("stall_release_epc", EPC, 32'h204);
        INT = 1'b0;
        step();
        chk("pre_rst_int_code", 32'(int_code), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_pc", PC_out, 32'h0);
        chk("arst_epc", EPC, 32'h0);
        chk("arst_int_code", 32'(int_code), 32'h0);
        chk("arst_int_taken", 32'(int_taken), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst_pc", PC_out, 32'h4);
        chk("after_rst_int_code", 32'(int_code), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
